// File: rtl/counter.sv
// counter: WIDTH-bit up/down counter with async active-low reset; wraps by default, saturates when COUNTER_SATURATE_EN is defined
module counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] out
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  // next count: step one in the sampled direction, clamping at the ends in the saturating build
  always_comb begin
`ifdef COUNTER_SATURATE_EN
    w_next = up_down ? ((r_count == MAX) ? r_count : r_count + ONE)
                     : ((r_count == '0)  ? r_count : r_count - ONE);
`else
    w_next = up_down ? r_count + ONE : r_count - ONE;
`endif
  end
  // count register: cleared immediately by reset, otherwise advances on every rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_count <= '0;
    else      r_count <= w_next;
  end
  assign out = r_count;
endmodule

// File: tb/tb_counter.sv
// tb_counter: table, directed and randomized checks of counter against an arithmetic reference model
module tb_counter;
  localparam int W = 3;
  localparam int M = 1 << W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_down = 1'b0;
  logic [W-1:0] out;
  int n_cmp = 0;
  int n_bad = 0;
  int m = 0;
  typedef struct {
    logic         rst;
    logic         up;
    logic [W-1:0] exp;
  } vec_t;
  vec_t v[$];

  counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .up_down(up_down), .out(out));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int nxt(input int c, input bit up);
`ifdef COUNTER_SATURATE_EN
    return up ? ((c == M - 1) ? c : c + 1) : ((c == 0) ? 0 : c - 1);
`else
    return up ? (c + 1) % M : (c + M - 1) % M;
`endif
  endfunction

  task automatic step(input logic r, input logic up);
    @(negedge clk);
    rst = r;
    up_down = up;
    @(posedge clk);
    #1;
    m = r ? nxt(m, up) : 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) v.push_back('{1'b0, logic'(i % 2), W'(0)});
`ifdef COUNTER_SATURATE_EN
    for (int i = 1; i <= 10; i++) v.push_back('{1'b1, 1'b1, W'((i < M - 1) ? i : M - 1)});
    for (int i = 1; i <= 9; i++) v.push_back('{1'b1, 1'b0, W'((M - 1 - i > 0) ? M - 1 - i : 0)});
`else
    for (int i = 1; i <= 8; i++) v.push_back('{1'b1, 1'b1, W'(i % M)});
    for (int i = 1; i <= 4; i++) v.push_back('{1'b1, 1'b0, W'(M - i)});
`endif
    #2 rst = 1'b0;
    #1 chk("reset_initial", out, W'(0));
    foreach (v[i]) begin
      step(v[i].rst, v[i].up);
      chk("table", out, v[i].exp);
    end
    step(1'b0, 1'b1);
    chk("dir_reset", out, W'(0));
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1);
      chk("dir_up", out, W'(i));
    end
    step(1'b1, 1'b0);
    chk("dir_change_first", out, W'(2));
    step(1'b1, 1'b0);
    chk("dir_change_second", out, W'(1));
    for (int i = 2; i <= 5; i++) begin
      step(1'b1, 1'b1);
      chk("pre_async", out, W'(i));
    end
    #3 rst = 1'b0;
    #1 chk("async_clear", out, W'(0));
    m = 0;
    step(1'b0, 1'b1);
    chk("async_hold", out, W'(0));
    step(1'b1, 1'b1);
    chk("async_resume", out, W'(1));
    @(negedge clk);
    up_down = 1'b0;
    #1 up_down = 1'b1;
    #1 up_down = 1'b0;
    #1 chk("glitch_no_effect", out, W'(1));
    @(posedge clk);
    #1 m = nxt(m, 1'b0);
    chk("glitch_sample", out, W'(m));
    for (int i = 0; i < 300; i++) begin
      step(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 1)));
      chk("random", out, W'(m));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
